des_round_sequencer: RTL and testbench

Control FSM that sequences the 16-round DES datapath.
- Issues load, per-round and final-permutation enables.
- Generates the key-schedule shift amount and direction for each round.
- In step mode, advances one round per strobe from the clock-divider tick generator, so each round can be shown on the board display.
- In run mode, advances one round per clock.

---
 rtl/des_round_sequencer.sv | 159 +++++++++++++++
 tb/tb_des_round_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/des_round_sequencer.sv
// Control sequencer for a 16-round DES datapath. It issues the load, per-round
// and final-permutation enables and decodes the key-schedule rotation amount
// and direction for the current round. In step mode each stage waits for a
// tick strobe so the rounds can be watched on the board display.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start; round_idx held at 0
// S_LOAD  | one cycle: load plaintext/key, apply initial permutation
// S_ROUND | one round per advance; round_idx walks 0..ROUNDS-1
// S_FINAL | on advance: swap halves, final permutation, capture result
// S_DONE  | one cycle: result valid, then back to idle
module des_round_sequencer #(
   parameter int ROUNDS = 16,
   parameter int IDX_W  = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic             i_decrypt,
   input  logic             i_step_mode,
   input  logic             i_tick_en,
   input  logic             i_abort,
   output logic             o_busy,
   output logic             o_load_en,
   output logic             o_round_en,
   output logic [IDX_W-1:0] o_round_idx,
   output logic [1:0]       o_shift_amt,
   output logic             o_key_dir,
   output logic             o_final_en,
   output logic             o_done
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_ROUND = 3'd2,
      S_FINAL = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [IDX_W-1:0] r_round_idx;
   logic [IDX_W-1:0] w_idx_nxt;
   logic             r_key_dir;
   logic             w_dir_nxt;
   logic             r_busy;
   logic             r_load_en;
   logic             r_done;
   logic             w_advance;
   logic             w_round_en;
   logic             w_final_en;
   logic [1:0]       w_shift_amt;

   // State, round index and key direction registers; stage flags are
   // registered from the next state so they line up with the state itself.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_round_idx <= '0;
         r_key_dir   <= 1'b0;
         r_busy      <= 1'b0;
         r_load_en   <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_round_idx <= w_idx_nxt;
         r_key_dir   <= w_dir_nxt;
         r_busy      <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_ROUND) ||
                        (w_state_nxt == S_FINAL);
         r_load_en   <= (w_state_nxt == S_LOAD);
         r_done      <= (w_state_nxt == S_DONE);
      end
   end

   // Next-state logic. Round and final pulses must coincide with the tick that
   // advances them, so they are decoded from the current cycle's advance/abort.
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_round_idx;
      w_dir_nxt   = r_key_dir;
      w_round_en  = 1'b0;
      w_final_en  = 1'b0;
      w_advance   = i_step_mode ? i_tick_en : 1'b1;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_state_nxt = S_LOAD;
               w_idx_nxt   = '0;
               w_dir_nxt   = i_decrypt;
            end
         end
         S_LOAD: begin
            if (i_abort) begin
               w_state_nxt = S_IDLE;
               w_idx_nxt   = '0;
            end else begin
               w_state_nxt = S_ROUND;
            end
         end
         S_ROUND: begin
            if (i_abort) begin
               w_state_nxt = S_IDLE;
               w_idx_nxt   = '0;
            end else if (w_advance) begin
               w_round_en = 1'b1;
               if (r_round_idx == LAST_IDX) begin
                  w_state_nxt = S_FINAL;
               end else begin
                  w_idx_nxt = r_round_idx + IDX_W'(1);
               end
            end
         end
         S_FINAL: begin
            if (i_abort) begin
               w_state_nxt = S_IDLE;
               w_idx_nxt   = '0;
            end else if (w_advance) begin
               w_final_en  = 1'b1;
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = '0;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = '0;
         end
      endcase
   end

   // Key rotation table: rounds 0, 1, 8 and 15 rotate by one. Decryption runs
   // the schedule backwards from the encrypt end state, so round 0 needs none.
   always_comb begin
      w_shift_amt = 2'd2;
      if (r_round_idx == IDX_W'(0)) begin
         w_shift_amt = r_key_dir ? 2'd0 : 2'd1;
      end else if ((r_round_idx == IDX_W'(1)) || (r_round_idx == IDX_W'(8)) ||
                   (r_round_idx == IDX_W'(15))) begin
         w_shift_amt = 2'd1;
      end
   end

   // A reset in the same cycle must also suppress the strobe-driven pulses.
   assign o_round_en  = w_round_en & ~i_rst;
   assign o_final_en  = w_final_en & ~i_rst;
   assign o_busy      = r_busy;
   assign o_load_en   = r_load_en;
   assign o_done      = r_done;
   assign o_round_idx = r_round_idx;
   assign o_key_dir   = r_key_dir;
   assign o_shift_amt = w_shift_amt;

endmodule

// File: tb/tb_des_round_sequencer.sv
// Bench for des_round_sequencer: stimulus pushes expected pulse events into a
// queue, a negedge monitor pops and compares each pulse the sequencer emits.
module tb_des_round_sequencer;

   logic       i_clk = 1'b0;
   logic       i_rst, i_start, i_decrypt, i_step_mode, i_tick_en, i_abort;
   logic       o_busy, o_load_en, o_round_en, o_key_dir, o_final_en, o_done;
   logic [3:0] o_round_idx;
   logic [1:0] o_shift_amt;

   typedef struct {
      int kind;   // 0 load, 1 round, 2 final, 3 done
      int cyc;
      int idx;
      int sh;
      int dir;
   } ev_t;

   ev_t q[$];
   int  cyc      = 0;
   int  checks   = 0;
   int  failures = 0;
   bit  mon_en   = 1'b0;
   int  enc_sh[16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
   int  dec_sh[16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   des_round_sequencer #(.ROUNDS(16), .IDX_W(4)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_decrypt(i_decrypt),
      .i_step_mode(i_step_mode), .i_tick_en(i_tick_en), .i_abort(i_abort),
      .o_busy(o_busy), .o_load_en(o_load_en), .o_round_en(o_round_en),
      .o_round_idx(o_round_idx), .o_shift_amt(o_shift_amt), .o_key_dir(o_key_dir),
      .o_final_en(o_final_en), .o_done(o_done)
   );

   always #10 i_clk = ~i_clk;
   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic do_cycle();
      @(posedge i_clk);
      #1;
   endtask

   task automatic push(input int kind, input int c, input int idx, input int sh, input int dir);
      ev_t e;
      e.kind = kind; e.cyc = c; e.idx = idx; e.sh = sh; e.dir = dir;
      q.push_back(e);
   endtask

   // Expected events for an uninterrupted run-mode block accepted at cycle c0.
   task automatic push_block(input int c0, input int dir);
      push(0, c0 + 1, 0, 0, dir);
      for (int i = 0; i < 16; i++)
         push(1, c0 + 2 + i, i, dir ? dec_sh[i] : enc_sh[i], dir);
      push(2, c0 + 18, 15, 0, dir);
      push(3, c0 + 19, 0, 0, dir);
   endtask

   // Monitor: every pulse must match the head of the expected queue.
   always @(negedge i_clk) begin
      if (mon_en && (o_load_en || o_round_en || o_final_en || o_done)) begin
         int   kind;
         int   n;
         ev_t  e;
         n = int'(o_load_en) + int'(o_round_en) + int'(o_final_en) + int'(o_done);
         chk("onehot_pulses", n, 1);
         kind = o_load_en ? 0 : o_round_en ? 1 : o_final_en ? 2 : 3;
         if (q.size() == 0) begin
            chk("unexpected_pulse_kind", kind, -1);
         end else begin
            e = q.pop_front();
            chk("pulse_kind", kind, e.kind);
            chk("pulse_cycle", cyc, e.cyc);
            chk("pulse_key_dir", int'(o_key_dir), e.dir);
            if (e.kind == 1) begin
               chk("round_idx", int'(o_round_idx), e.idx);
               chk("shift_amt", int'(o_shift_amt), e.sh);
            end
         end
      end
   end

   // Full run-mode block, also checking busy over cycles 1..20.
   task automatic run_full(input int dir);
      int c0;
      c0 = cyc;
      i_decrypt = dir[0];
      i_start   = 1'b1;
      push_block(c0, dir);
      do_cycle();
      i_start = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         chk("busy_run", int'(o_busy), (k <= 18) ? 1 : 0);
         do_cycle();
      end
   endtask

   initial begin
      int c0;
      int nt;
      int fin_c;
      i_rst = 1'b1; i_start = 1'b0; i_decrypt = 1'b0; i_step_mode = 1'b0;
      i_tick_en = 1'b0; i_abort = 1'b0;
      repeat (3) do_cycle();
      i_rst = 1'b0;
      mon_en = 1'b1;
      chk("reset_busy", int'(o_busy), 0);
      chk("reset_round_idx", int'(o_round_idx), 0);
      chk("reset_key_dir", int'(o_key_dir), 0);
      chk("reset_load_en", int'(o_load_en), 0);
      chk("reset_done", int'(o_done), 0);
      do_cycle();

      // Run-mode encrypt.
      run_full(0);

      // Run-mode decrypt with ignored starts at 5 (ROUND) and 19 (DONE), a
      // decrypt flip after acceptance, then a start at 20 that is accepted.
      c0 = cyc;
      i_decrypt = 1'b1;
      i_start   = 1'b1;
      push_block(c0, 1);
      for (int k = 1; k <= 20; k++) begin
         do_cycle();
         i_start = (k == 5 || k == 19) ? 1'b1 : 1'b0;
         if (k == 3) i_decrypt = 1'b0;
         if (k == 19) chk("done_key_dir", int'(o_key_dir), 1);
      end
      run_full(0);

      // Step mode, tick every 5th cycle; the tick landing in LOAD is ignored.
      i_step_mode = 1'b1;
      for (int k = 0; k < 5 && (cyc % 5) != 4; k++) do_cycle();
      c0 = cyc;
      i_decrypt = 1'b0;
      i_start   = 1'b1;
      push(0, c0 + 1, 0, 0, 0);
      do_cycle();
      i_start = 1'b0;
      nt    = 0;
      fin_c = -10;
      for (int k = 0; k < 120 && cyc <= fin_c + 2 || k == 0 || fin_c < 0; k++) begin
         if (k >= 120) break;
         i_tick_en = ((cyc % 5) == 0);
         if (i_tick_en && cyc >= c0 + 2 && fin_c < 0) begin
            if (nt < 16) begin
               push(1, cyc, nt, enc_sh[nt], 0);
            end else begin
               push(2, cyc, 15, 0, 0);
               push(3, cyc + 1, 0, 0, 0);
               fin_c = cyc;
            end
            nt++;
         end
         if (cyc > c0 + 1 && cyc <= fin_c + 0 || (fin_c < 0 && cyc > c0))
            chk("busy_step", int'(o_busy), 1);
         do_cycle();
      end
      i_tick_en   = 1'b0;
      i_step_mode = 1'b0;
      chk("step_final_tick_number", nt, 17);
      repeat (2) do_cycle();

      // Abort while round_idx is 7.
      c0 = cyc;
      i_decrypt = 1'b0;
      i_start   = 1'b1;
      push(0, c0 + 1, 0, 0, 0);
      for (int i = 0; i < 7; i++) push(1, c0 + 2 + i, i, enc_sh[i], 0);
      for (int k = 1; k <= 9; k++) begin
         do_cycle();
         i_start = 1'b0;
      end
      chk("abort_at_idx", int'(o_round_idx), 7);
      i_abort = 1'b1;
      do_cycle();
      i_abort = 1'b0;
      chk("abort_busy", int'(o_busy), 0);
      chk("abort_round_idx", int'(o_round_idx), 0);
      repeat (25) do_cycle();
      run_full(0);

      // Reset during FINAL in step mode with tick high.
      i_step_mode = 1'b1;
      i_tick_en   = 1'b1;
      c0 = cyc;
      i_decrypt = 1'b1;
      i_start   = 1'b1;
      push(0, c0 + 1, 0, 0, 1);
      for (int i = 0; i < 16; i++) push(1, c0 + 2 + i, i, dec_sh[i], 1);
      for (int k = 1; k <= 18; k++) begin
         do_cycle();
         i_start = 1'b0;
      end
      i_rst = 1'b1;
      #1;
      chk("rst_final_en", int'(o_final_en), 0);
      do_cycle();
      chk("rst_busy", int'(o_busy), 0);
      chk("rst_round_idx", int'(o_round_idx), 0);
      chk("rst_key_dir", int'(o_key_dir), 0);
      chk("rst_done", int'(o_done), 0);
      chk("rst_load_en", int'(o_load_en), 0);
      i_rst = 1'b0;
      i_tick_en = 1'b0;
      i_step_mode = 1'b0;
      repeat (5) do_cycle();

      chk("events_outstanding", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
